// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC and instruction register, fetches over a
// req/ack handshake and applies the control word's PS/IL/K fields.
module instruction_fetch_unit #(
  parameter int                 ADDR_W   = 64,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 TIMEOUT  = 15
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [1:0]        i_ps,
  input  logic              i_il,
  input  logic              i_imm_sel,
  input  logic [63:0]       i_k,
  input  logic [63:0]       i_bus_in,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic [31:0]       i_imem_rdata,
  input  logic              i_imem_ack,
  output logic [31:0]       o_instruction,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_pc_plus4,
  output logic              o_stall,
  output logic              o_fetch_fault
);

  localparam int              CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam bit              TO_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {S_IDLE, S_FETCH} state_t;

  state_t              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_pc, w_pc_next;
  logic [31:0]         r_instr, w_instr_next;
  logic                r_req, w_req_next;
  logic [ADDR_W-1:0]   r_addr, w_addr_next;
  logic                r_fault, w_fault_next;
  logic [CNT_W-1:0]    r_cnt, w_cnt_next;
  logic                w_capture;
  logic                w_stall;

  logic [1:0]          r_pend_ps;
  logic                r_pend_sel;
  logic [25:0]         r_pend_k;
  logic [ADDR_W-1:0]   r_pend_bus;

  logic [ADDR_W-1:0]   w_bus;
  logic                w_unused_k;

  assign w_bus      = ADDR_W'(i_bus_in);
  assign w_unused_k = ^i_k[63:26];

  // Branch offsets are word offsets: sign-extend the selected field, then scale by 4.
  function automatic logic [ADDR_W-1:0] f_pc_update(
    input logic [1:0]        ps,
    input logic              imm_sel,
    input logic [25:0]       k,
    input logic [ADDR_W-1:0] bus,
    input logic [ADDR_W-1:0] pc
  );
    logic [ADDR_W-1:0] off;
    if (imm_sel) off = {{(ADDR_W-26){k[25]}}, k[25:0]};
    else         off = {{(ADDR_W-19){k[18]}}, k[18:0]};
    case (ps)
      2'b00:   f_pc_update = pc;
      2'b01:   f_pc_update = pc + ADDR_W'(4);
      2'b10:   f_pc_update = pc + (off << 2);
      default: f_pc_update = bus;
    endcase
  endfunction

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_instr_next = r_instr;
    w_req_next   = r_req;
    w_addr_next  = r_addr;
    w_fault_next = r_fault;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
    w_stall      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_il) begin
          w_stall      = 1'b1;
          w_capture    = 1'b1;
          w_addr_next  = r_pc;
          w_req_next   = 1'b1;
          w_fault_next = 1'b0;
          w_cnt_next   = '0;
          w_state_next = S_FETCH;
        end else begin
          w_pc_next = f_pc_update(i_ps, i_imm_sel, i_k[25:0], w_bus, r_pc);
        end
      end
      S_FETCH: begin
        if (i_imem_ack) begin
          w_instr_next = i_imem_rdata;
          w_req_next   = 1'b0;
          w_state_next = S_IDLE;
          w_pc_next    = f_pc_update(r_pend_ps, r_pend_sel, r_pend_k, r_pend_bus, r_pc);
        end else begin
          w_stall    = 1'b1;
          w_cnt_next = r_cnt + CNT_W'(1);
          // Give up on the fetch; PC and instruction stay where they were.
          if (TO_EN && (r_cnt == CNT_LAST)) begin
            w_req_next   = 1'b0;
            w_fault_next = 1'b1;
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_req      <= 1'b0;
      r_addr     <= '0;
      r_fault    <= 1'b0;
      r_cnt      <= '0;
      r_pend_ps  <= '0;
      r_pend_sel <= 1'b0;
      r_pend_k   <= '0;
      r_pend_bus <= '0;
    end else begin
      r_pc    <= w_pc_next;
      r_instr <= w_instr_next;
      r_req   <= w_req_next;
      r_addr  <= w_addr_next;
      r_fault <= w_fault_next;
      r_cnt   <= w_cnt_next;
      if (w_capture) begin
        r_pend_ps  <= i_ps;
        r_pend_sel <= i_imm_sel;
        r_pend_k   <= i_k[25:0];
        r_pend_bus <= w_bus;
      end
    end
  end

  assign o_imem_req    = r_req;
  assign o_imem_addr   = r_addr;
  assign o_instruction = r_instr;
  assign o_pc          = r_pc;
  assign o_pc_plus4    = r_pc + ADDR_W'(4);
  assign o_stall       = w_stall;
  assign o_fetch_fault = r_fault;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit (TIMEOUT=4); inputs change on the
// falling edge, outputs are sampled on the falling edge or 1ns after a drive.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  i_ps;
  logic        i_il;
  logic        i_imm_sel;
  logic [63:0] i_k;
  logic [63:0] i_bus_in;
  logic        o_imem_req;
  logic [63:0] o_imem_addr;
  logic [31:0] i_imem_rdata;
  logic        i_imem_ack;
  logic [31:0] o_instruction;
  logic [63:0] o_pc;
  logic [63:0] o_pc_plus4;
  logic        o_stall;
  logic        o_fetch_fault;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_instr;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.ADDR_W(64), .RESET_PC(64'h0), .TIMEOUT(4)) dut (
    .i_clock(clk), .i_reset(rst), .i_ps(i_ps), .i_il(i_il), .i_imm_sel(i_imm_sel),
    .i_k(i_k), .i_bus_in(i_bus_in), .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_rdata(i_imem_rdata), .i_imem_ack(i_imem_ack), .o_instruction(o_instruction),
    .o_pc(o_pc), .o_pc_plus4(o_pc_plus4), .o_stall(o_stall), .o_fetch_fault(o_fetch_fault)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic idle_op(input logic [1:0] ps_v, input logic sel, input logic [63:0] k_v,
                         input logic [63:0] bus_v, input logic [63:0] exp_pc, input string tag);
    i_il = 1'b0; i_ps = ps_v; i_imm_sel = sel; i_k = k_v; i_bus_in = bus_v;
    #1 chk({tag, "_stall"}, o_stall, 0);
    @(negedge clk);
    chk({tag, "_pc"}, o_pc, exp_pc);
    i_ps = 2'b00;
  endtask

  task automatic set_pc(input logic [63:0] v);
    idle_op(2'b11, 1'b0, 64'h0, v, v, "set_pc");
  endtask

  task automatic fetch(input logic [1:0] ps_v, input logic sel, input logic [63:0] k_v,
                       input logic [63:0] bus_v, input int waits, input logic [31:0] data,
                       input logic [63:0] exp_addr, input logic [63:0] exp_pc, input string tag);
    int sc;
    sc = 0;
    i_il = 1'b1; i_ps = ps_v; i_imm_sel = sel; i_k = k_v; i_bus_in = bus_v;
    #1 if (o_stall) sc++;
    @(negedge clk);
    // Junk on the control inputs while fetching must have no effect.
    i_il = 1'b0; i_ps = 2'b11; i_bus_in = 64'hBAD0; i_k = '1;
    chk({tag, "_req"}, o_imem_req, 1);
    chk({tag, "_addr"}, o_imem_addr, exp_addr);
    chk({tag, "_fault_clr"}, o_fetch_fault, 0);
    for (int w = 0; w < waits; w++) begin
      #1 if (o_stall) sc++;
      @(negedge clk);
      chk({tag, "_addr_hold"}, o_imem_addr, exp_addr);
    end
    i_imem_ack = 1'b1; i_imem_rdata = data;
    #1 if (o_stall) sc++;
    @(negedge clk);
    i_imem_ack = 1'b0; i_ps = 2'b00;
    exp_instr = data;
    chk({tag, "_instr"}, o_instruction, data);
    chk({tag, "_pc"}, o_pc, exp_pc);
    chk({tag, "_req_drop"}, o_imem_req, 0);
    chk({tag, "_fault"}, o_fetch_fault, 0);
    chk({tag, "_stall_cycles"}, sc, waits + 1);
  endtask

  initial begin
    rst = 1'b1; i_ps = 2'b00; i_il = 1'b0; i_imm_sel = 1'b0; i_k = '0; i_bus_in = '0;
    i_imem_rdata = '0; i_imem_ack = 1'b0; exp_instr = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_pc", o_pc, 0);
    chk("rst_instr", o_instruction, 0);
    chk("rst_req", o_imem_req, 0);
    chk("rst_addr", o_imem_addr, 0);
    chk("rst_fault", o_fetch_fault, 0);
    chk("rst_pc_plus4", o_pc_plus4, 4);
    rst = 1'b0;

    set_pc(64'h100);
    chk("pc_plus4", o_pc_plus4, 64'h104);
    fetch(2'b01, 1'b0, 64'h0, 64'h0, 0, 32'h8B020020, 64'h100, 64'h104, "zero_wait");

    // Three waits with TIMEOUT=4: the ack lands on the last allowed cycle.
    set_pc(64'h200);
    fetch(2'b10, 1'b1, 64'h3FFFFFC, 64'h0, 3, 32'h12345678, 64'h200, 64'h1F0, "b_back");

    set_pc(64'h200);
    idle_op(2'b10, 1'b0, 64'h10,    64'h0, 64'h240,    "cb_fwd");
    idle_op(2'b10, 1'b1, 64'h40000, 64'h0, 64'h100240, "b_sel26");
    idle_op(2'b10, 1'b0, 64'h7FFFF, 64'h0, 64'h10023C, "cb_neg");
    idle_op(2'b00, 1'b1, 64'h55,    64'h77, 64'h10023C, "hold");
    idle_op(2'b11, 1'b0, 64'h0, 64'hDEAD0000, 64'hDEAD0000, "br");
    set_pc(64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_pc_plus4", o_pc_plus4, 0);
    idle_op(2'b01, 1'b0, 64'h0, 64'h0, 64'h0, "wrap");

    // Timeout: no ack for 4 FETCH cycles.
    set_pc(64'h300);
    i_il = 1'b1; i_ps = 2'b01;
    #1 chk("to_il_stall", o_stall, 1);
    @(negedge clk);
    i_il = 1'b0; i_ps = 2'b00;
    for (int c = 0; c < 4; c++) begin
      chk("to_req_high", o_imem_req, 1);
      #1 chk("to_stall", o_stall, 1);
      @(negedge clk);
    end
    chk("to_req_drop", o_imem_req, 0);
    chk("to_fault", o_fetch_fault, 1);
    chk("to_pc", o_pc, 64'h300);
    chk("to_instr", o_instruction, exp_instr);

    // A stray ack in IDLE is ignored and the fault stays up.
    i_imem_ack = 1'b1; i_imem_rdata = 32'hFFFF_FFFF;
    #1 chk("late_ack_stall", o_stall, 0);
    @(negedge clk);
    i_imem_ack = 1'b0;
    chk("late_ack_instr", o_instruction, exp_instr);
    chk("late_ack_pc", o_pc, 64'h300);
    chk("fault_sticky", o_fetch_fault, 1);
    fetch(2'b01, 1'b0, 64'h0, 64'h0, 0, 32'hCAFEF00D, 64'h300, 64'h304, "clr");

    // Reset in the middle of a fetch.
    i_il = 1'b1; i_ps = 2'b01;
    @(negedge clk);
    i_il = 1'b0; i_ps = 2'b00;
    chk("mid_req", o_imem_req, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", o_imem_req, 0);
    chk("mid_rst_pc", o_pc, 0);
    chk("mid_rst_instr", o_instruction, 0);
    chk("mid_rst_addr", o_imem_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("mid_rst_idle_stall", o_stall, 0);
    @(negedge clk);
    fetch(2'b01, 1'b0, 64'h0, 64'h0, 0, 32'hA5A5A5A5, 64'h0, 64'h4, "post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
